// File: rtl/des_keygen_arbiter_if.sv
// Bundle between the two cipher-core requesters, the arbiter and the shared DES
// round-key generator.
//   req/key0/key1          requester side into the arbiter
//   gnt/kn/kn_valid/...    arbiter results back to the requesters
//   kg_start/kg_key        arbiter to keygen
//   kg_kn/kg_out_valid/... keygen back to the arbiter
// The master modport is the arbiter. The slave modport is the environment, which
// is the requesters plus the keygen.
interface des_keygen_arbiter_if;
  logic [1:0]  req;
  logic [63:0] key0;
  logic [63:0] key1;
  logic [1:0]  gnt;
  logic [47:0] kn;
  logic        kn_valid;
  logic [3:0]  kn_round;
  logic [1:0]  done;
  logic        err;
  logic        kg_start;
  logic [63:0] kg_key;
  logic [47:0] kg_kn;
  logic        kg_out_valid;
  logic        kg_done;

  modport master (
    input  req, key0, key1, kg_kn, kg_out_valid, kg_done,
    output gnt, kn, kn_valid, kn_round, done, err, kg_start, kg_key
  );

  modport slave (
    output req, key0, key1, kg_kn, kg_out_valid, kg_done,
    input  gnt, kn, kn_valid, kn_round, done, err, kg_start, kg_key
  );
endinterface

// File: rtl/des_keygen_arbiter.sv
// Shares one DES round-key generator between two requesters.
// The arbiter picks an owner round-robin and latches that owner's key. It then
// pulses kg_start, forwards up to NUM_ROUNDS Kn words with a round index, and
// pulses done[owner] when the keygen reports completion.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    des_keygen_arbiter_if.master, carrying the requester and keygen signals
// Optional feature: macro DES_KGARB_WDOG_EN adds a watchdog. If kg_done does not
// arrive within WDOG_CYCLES cycles of kg_start, the job is aborted with an err
// pulse. Without the macro err is tied to 0.
module des_keygen_arbiter #(
  parameter int unsigned NUM_ROUNDS = 16
`ifdef DES_KGARB_WDOG_EN
  , parameter int unsigned WDOG_CYCLES = 40
`endif
) (
  input logic                  clk,
  input logic                  rst_n,
  des_keygen_arbiter_if.master bus
);
  localparam int unsigned CntW = $clog2(NUM_ROUNDS + 1);

  typedef enum logic [2:0] {StIdle, StGrant, StStart, StRun, StFin} state_e;

  state_e          state_q, state_d;
  logic [1:0]      gnt_q, gnt_d;
  logic [1:0]      done_q, done_d;
  logic            kg_start_q, kg_start_d;
  logic [63:0]     kg_key_q, kg_key_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            prio_q, prio_d;  // 1: requester 1 wins a tie
  logic            pick1;
  logic            beat_ok;

`ifdef DES_KGARB_WDOG_EN
  localparam int unsigned WdogW = $clog2(WDOG_CYCLES + 1);
  logic [WdogW-1:0] wdog_q, wdog_d;
  logic             err_q, err_d;
  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign pick1   = bus.req[1] && (!bus.req[0] || prio_q);
  assign beat_ok = (state_q == StRun) && bus.kg_out_valid && (cnt_q < CntW'(NUM_ROUNDS));

  assign bus.kn       = bus.kg_kn;
  assign bus.kn_valid = beat_ok;
  assign bus.kn_round = 4'(cnt_q);
  assign bus.gnt      = gnt_q;
  assign bus.done     = done_q;
  assign bus.kg_start = kg_start_q;
  assign bus.kg_key   = kg_key_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = 2'b00;
    kg_start_d = 1'b0;
    kg_key_d   = kg_key_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
`ifdef DES_KGARB_WDOG_EN
    wdog_d     = wdog_q;
    err_d      = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          gnt_d    = pick1 ? 2'b10 : 2'b01;
          kg_key_d = pick1 ? bus.key1 : bus.key0;
          state_d  = StGrant;
        end
      end
      StGrant: begin
        kg_start_d = 1'b1;  // registered, so it is high during StStart
        state_d    = StStart;
      end
      StStart: begin
        cnt_d   = '0;
`ifdef DES_KGARB_WDOG_EN
        wdog_d  = WdogW'(1);  // the kg_start cycle counts as cycle 0
`endif
        state_d = StRun;
      end
      StRun: begin
        if (beat_ok) cnt_d = cnt_q + CntW'(1);
`ifdef DES_KGARB_WDOG_EN
        wdog_d = wdog_q + WdogW'(1);
`endif
        if (bus.kg_done) begin
          done_d  = gnt_q;
          gnt_d   = 2'b00;
          prio_d  = ~gnt_q[1];
          state_d = StFin;
`ifdef DES_KGARB_WDOG_EN
        end else if (wdog_q == WdogW'(WDOG_CYCLES - 1)) begin
          // The abort is a separate outcome: done is not pulsed.
          err_d   = 1'b1;
          gnt_d   = 2'b00;
          prio_d  = ~gnt_q[1];
          state_d = StIdle;
`endif
        end
      end
      StFin: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = 2'b00;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      gnt_q      <= 2'b00;
      done_q     <= 2'b00;
      kg_start_q <= 1'b0;
      kg_key_q   <= '0;
      cnt_q      <= '0;
      prio_q     <= 1'b0;
`ifdef DES_KGARB_WDOG_EN
      wdog_q     <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      kg_start_q <= kg_start_d;
      kg_key_q   <= kg_key_d;
      cnt_q      <= cnt_d;
      prio_q     <= prio_d;
`ifdef DES_KGARB_WDOG_EN
      wdog_q     <= wdog_d;
      err_q      <= err_d;
`endif
    end
  end
endmodule

// File: tb/tb_des_keygen_arbiter.sv
// Directed bench for des_keygen_arbiter. The bench plays both requesters and the keygen.
module tb_des_keygen_arbiter;
  localparam logic [63:0] KeyA = 64'h133457799BBCDFF1;
  localparam logic [63:0] KeyB = 64'h0E329232EA6D0D73;
  localparam logic [47:0] K1   = 48'h1B02EFFC7072;
  localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  logic        obs_valid [32];
  logic [3:0]  obs_round [32];
  logic [47:0] obs_kn [32];
  int          nvalid;

  des_keygen_arbiter_if bus ();
  des_keygen_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  function automatic logic [47:0] kn_tab(input int i);
    if (i == 0) return K1;
    if (i == 15) return K16;
    return {16'hA5A5, 32'(i)};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.kg_out_valid = 1'b0;
    bus.kg_done = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  // Keygen model: n beats, kg_done raised on beat done_at (-1 = never).
  task automatic drive_beats(input int n, input int done_at);
    nvalid = 0;
    for (int i = 0; i < n; i++) begin
      bus.kg_out_valid = 1'b1;
      bus.kg_kn = kn_tab(i);
      bus.kg_done = (i == done_at);
      #1;
      obs_valid[i] = bus.kn_valid;
      obs_round[i] = bus.kn_round;
      obs_kn[i] = bus.kn;
      if (bus.kn_valid === 1'b1) nvalid++;
      step();
    end
    bus.kg_out_valid = 1'b0;
    bus.kg_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.req = 2'b00;
    bus.key0 = '0;
    bus.key1 = '0;
    bus.kg_kn = '0;
    bus.kg_out_valid = 1'b1;
    bus.kg_done = 1'b0;
    step();
    step();
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b want=00", bus.gnt); end
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL reset_done got=%b want=00", bus.done); end
    checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", bus.err); end
    checks++; if (bus.kg_start !== 1'b0) begin failures++; $display("FAIL reset_kg_start got=%b want=0", bus.kg_start); end
    checks++; if (bus.kg_key !== 64'h0) begin failures++; $display("FAIL reset_kg_key got=%h want=0", bus.kg_key); end
    checks++; if (bus.kn_valid !== 1'b0) begin failures++; $display("FAIL reset_kn_valid got=%b want=0", bus.kn_valid); end
    rst_n = 1'b1;
    bus.kg_out_valid = 1'b0;
    step();
  endtask

  task automatic test_single_job();
    bus.req = 2'b01;
    bus.key0 = KeyA;
    bus.key1 = KeyB;
    step();
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL single_gnt got=%b want=01", bus.gnt); end
    checks++; if (bus.kg_key !== KeyA) begin failures++; $display("FAIL single_kg_key got=%h want=%h", bus.kg_key, KeyA); end
    checks++; if (bus.kg_start !== 1'b0) begin failures++; $display("FAIL single_start_early got=%b want=0", bus.kg_start); end
    // Keygen outputs outside RUN must be ignored.
    bus.kg_out_valid = 1'b1;
    bus.kg_done = 1'b1;
    #1;
    checks++; if (bus.kn_valid !== 1'b0) begin failures++; $display("FAIL single_kn_valid_grant got=%b want=0", bus.kn_valid); end
    step();
    bus.kg_out_valid = 1'b0;
    bus.kg_done = 1'b0;
    checks++; if (bus.kg_start !== 1'b1) begin failures++; $display("FAIL single_kg_start got=%b want=1", bus.kg_start); end
    step();
    checks++; if (bus.kg_start !== 1'b0) begin failures++; $display("FAIL single_kg_start_len got=%b want=0", bus.kg_start); end
    drive_beats(16, 15);
    checks++; if (nvalid != 16) begin failures++; $display("FAIL single_nvalid got=%0d want=16", nvalid); end
    checks++; if (obs_kn[0] !== K1 || obs_round[0] !== 4'd0) begin failures++; $display("FAIL single_k1 got=%h/%0d want=%h/0", obs_kn[0], obs_round[0], K1); end
    checks++; if (obs_kn[15] !== K16 || obs_round[15] !== 4'd15) begin failures++; $display("FAIL single_k16 got=%h/%0d want=%h/15", obs_kn[15], obs_round[15], K16); end
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL single_done got=%b want=01", bus.done); end
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL single_gnt_clr got=%b want=00", bus.gnt); end
    bus.req = 2'b00;
    step();
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL single_done_len got=%b want=00", bus.done); end
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 2'b11;
    step();
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL rr_first got=%b want=01", bus.gnt); end
    step();
    step();
    drive_beats(16, 15);
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL rr_done0 got=%b want=01", bus.done); end
    step();
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL rr_idle got=%b want=00", bus.gnt); end
    step();
    checks++; if (bus.gnt !== 2'b10) begin failures++; $display("FAIL rr_second got=%b want=10", bus.gnt); end
    checks++; if (bus.kg_key !== KeyB) begin failures++; $display("FAIL rr_key1 got=%h want=%h", bus.kg_key, KeyB); end
    step();
    step();
    drive_beats(16, 15);
    checks++; if (bus.done !== 2'b10) begin failures++; $display("FAIL rr_done1 got=%b want=10", bus.done); end
    step();
    step();
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL rr_third got=%b want=01", bus.gnt); end
    step();
    step();
    drive_beats(2, 1);
    bus.req = 2'b00;
    step();
  endtask

  task automatic test_overflow();
    bus.req = 2'b01;
    step();
    step();
    step();
    drive_beats(18, 17);
    checks++; if (nvalid != 16) begin failures++; $display("FAIL ovf_nvalid got=%0d want=16", nvalid); end
    begin
      int bad = -1;
      for (int i = 0; i < 16; i++) if (obs_round[i] !== 4'(i) && bad < 0) bad = i;
      checks++; if (bad >= 0) begin failures++; $display("FAIL ovf_round idx=%0d got=%0d want=%0d", bad, obs_round[bad], bad); end
    end
    checks++; if (obs_valid[16] !== 1'b0 || obs_valid[17] !== 1'b0) begin failures++; $display("FAIL ovf_drop got=%b%b want=00", obs_valid[16], obs_valid[17]); end
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL ovf_done got=%b want=01", bus.done); end
    bus.req = 2'b00;
    step();
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL ovf_done_once got=%b want=00", bus.done); end
  endtask

  task automatic test_reset_mid();
    bus.req = 2'b01;
    step();
    step();
    step();
    drive_beats(7, -1);
    bus.kg_out_valid = 1'b1;
    bus.kg_kn = kn_tab(7);
    #1;
    checks++; if (bus.kn_round !== 4'd7) begin failures++; $display("FAIL rmid_round got=%0d want=7", bus.kn_round); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL rmid_gnt got=%b want=00", bus.gnt); end
    checks++; if (bus.kn_valid !== 1'b0) begin failures++; $display("FAIL rmid_kn_valid got=%b want=0", bus.kn_valid); end
    checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL rmid_done got=%b want=00", bus.done); end
    bus.kg_out_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL rmid_regnt got=%b want=01", bus.gnt); end
    step();
    step();
    drive_beats(1, 0);
    checks++; if (obs_round[0] !== 4'd0 || obs_valid[0] !== 1'b1) begin failures++; $display("FAIL rmid_restart got=%0d/%b want=0/1", obs_round[0], obs_valid[0]); end
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL rmid_done_end got=%b want=01", bus.done); end
    bus.req = 2'b00;
    step();
  endtask

  task automatic test_short_done();
    do_reset();
    bus.req = 2'b10;
    step();
    checks++; if (bus.gnt !== 2'b10) begin failures++; $display("FAIL short_gnt got=%b want=10", bus.gnt); end
    checks++; if (bus.kg_key !== KeyB) begin failures++; $display("FAIL short_key got=%h want=%h", bus.kg_key, KeyB); end
    step();
    step();
    drive_beats(5, 4);
    checks++; if (nvalid != 5) begin failures++; $display("FAIL short_nvalid got=%0d want=5", nvalid); end
    checks++; if (bus.done !== 2'b10) begin failures++; $display("FAIL short_done got=%b want=10", bus.done); end
    bus.req = 2'b00;
    step();
  endtask

  task automatic test_drop();
    bus.req = 2'b01;
    step();
    checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL drop_gnt got=%b want=01", bus.gnt); end
    step();
    step();
    drive_beats(3, -1);
    bus.req = 2'b00;
    drive_beats(13, 12);
    checks++; if (nvalid != 13) begin failures++; $display("FAIL drop_nvalid got=%0d want=13", nvalid); end
    checks++; if (obs_round[0] !== 4'd3 || obs_round[12] !== 4'd15) begin failures++; $display("FAIL drop_rounds got=%0d..%0d want=3..15", obs_round[0], obs_round[12]); end
    checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL drop_done got=%b want=01", bus.done); end
    step();
    step();
    checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL drop_no_regnt got=%b want=00", bus.gnt); end
  endtask

  task automatic test_watchdog();
    bus.req = 2'b01;
    step();
    step();
    checks++; if (bus.kg_start !== 1'b1) begin failures++; $display("FAIL wdog_start got=%b want=1", bus.kg_start); end
`ifdef DES_KGARB_WDOG_EN
    begin
      int waited = 0;
      while (waited < 100 && bus.err !== 1'b1) begin
        step();
        waited++;
      end
      checks++; if (waited != 40) begin failures++; $display("FAIL wdog_latency got=%0d want=40", waited); end
      checks++; if (bus.gnt !== 2'b00) begin failures++; $display("FAIL wdog_gnt got=%b want=00", bus.gnt); end
      checks++; if (bus.done !== 2'b00) begin failures++; $display("FAIL wdog_done got=%b want=00", bus.done); end
      bus.req = 2'b00;
      step();
      checks++; if (bus.err !== 1'b0) begin failures++; $display("FAIL wdog_err_len got=%b want=0", bus.err); end
    end
`else
    begin
      logic seen = 1'b0;
      for (int i = 0; i < 60; i++) begin
        step();
        if (bus.err !== 1'b0) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin failures++; $display("FAIL nowdog_err got=%b want=0", seen); end
      checks++; if (bus.gnt !== 2'b01) begin failures++; $display("FAIL nowdog_gnt got=%b want=01", bus.gnt); end
      drive_beats(1, 0);
      checks++; if (bus.done !== 2'b01) begin failures++; $display("FAIL nowdog_done got=%b want=01", bus.done); end
      bus.req = 2'b00;
      step();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single_job();
    test_round_robin();
    test_overflow();
    test_reset_mid();
    test_short_done();
    test_drop();
    test_watchdog();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end
endmodule
